// File: rtl/serial_operand_sequencer_if.sv
// rtl/serial_operand_sequencer_if.sv - operand load, serial bit and result bundle for the operand sequencer
interface serial_operand_sequencer_if #(
    parameter int WIDTH = 4
);
    logic             load_valid;
    logic             load_ready;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             ser_a;
    logic             ser_b;
    logic             ser_valid;
    logic             ser_first;
    logic             sum_bit;
    logic [WIDTH-1:0] result;
    logic             result_valid;

    // Sequencer side
    modport slave (
        input  load_valid,
        input  a_in,
        input  b_in,
        input  sum_bit,
        output load_ready,
        output ser_a,
        output ser_b,
        output ser_valid,
        output ser_first,
        output result,
        output result_valid
    );

    // Operand source plus serial adder side
    modport master (
        output load_valid,
        output a_in,
        output b_in,
        output sum_bit,
        input  load_ready,
        input  ser_a,
        input  ser_b,
        input  ser_valid,
        input  ser_first,
        input  result,
        input  result_valid
    );
endinterface

// File: rtl/serial_operand_sequencer.sv
// rtl/serial_operand_sequencer.sv - parallel-to-serial operand feeder and serial-to-parallel sum collector
module serial_operand_sequencer #(
    parameter int WIDTH = 4
) (
    input  logic                        clk,
    input  logic                        reset_n,
    serial_operand_sequencer_if.slave   bus
);
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_sh_q;
    logic [WIDTH-1:0] b_sh_q;
    logic [WIDTH-1:0] res_sh_q;
    logic [WIDTH-1:0] res_sh_d;
    logic [CNT_W-1:0] count_q;
    logic [WIDTH-1:0] result_q;
    logic             result_valid_q;
    logic             load_ready_q;
    logic             ser_valid_q;
    logic             ser_first_q;
    logic             ser_a_q;
    logic             ser_b_q;

    // Sum bit enters at the MSB so that after WIDTH shifts bit 0 sits at the LSB
    always_comb begin
        res_sh_d = (res_sh_q >> 1) | {bus.sum_bit, {(WIDTH-1){1'b0}}};
    end

    // Sequencer FSM; every output is a register computed for the state being entered
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            a_sh_q         <= '0;
            b_sh_q         <= '0;
            res_sh_q       <= '0;
            count_q        <= '0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            load_ready_q   <= 1'b1;
            ser_valid_q    <= 1'b0;
            ser_first_q    <= 1'b0;
            ser_a_q        <= 1'b0;
            ser_b_q        <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.load_valid) begin
                        a_sh_q       <= bus.a_in;
                        b_sh_q       <= bus.b_in;
                        count_q      <= '0;
                        state_q      <= SHIFT;
                        load_ready_q <= 1'b0;
                        ser_valid_q  <= 1'b1;
                        ser_first_q  <= 1'b1;
                        ser_a_q      <= bus.a_in[0];
                        ser_b_q      <= bus.b_in[0];
                    end
                end
                SHIFT: begin
                    a_sh_q      <= a_sh_q >> 1;
                    b_sh_q      <= b_sh_q >> 1;
                    res_sh_q    <= res_sh_d;
                    ser_first_q <= 1'b0;
                    if (count_q == LAST_BIT) begin
                        // The final sum bit completes res_sh on this edge; publishing it now
                        // lets result already hold the new sum while result_valid is high in DONE.
                        count_q        <= '0;
                        state_q        <= DONE;
                        result_q       <= res_sh_d;
                        result_valid_q <= 1'b1;
                        ser_valid_q    <= 1'b0;
                        ser_a_q        <= 1'b0;
                        ser_b_q        <= 1'b0;
                    end else begin
                        count_q <= count_q + CNT_W'(1);
                        ser_a_q <= a_sh_q[1];
                        ser_b_q <= b_sh_q[1];
                    end
                end
                DONE: begin
                    result_valid_q <= 1'b0;
                    load_ready_q   <= 1'b1;
                    state_q        <= IDLE;
                end
                default: begin
                    state_q        <= IDLE;
                    count_q        <= '0;
                    result_valid_q <= 1'b0;
                    load_ready_q   <= 1'b1;
                    ser_valid_q    <= 1'b0;
                    ser_first_q    <= 1'b0;
                    ser_a_q        <= 1'b0;
                    ser_b_q        <= 1'b0;
                end
            endcase
        end
    end

    assign bus.load_ready   = load_ready_q;
    assign bus.ser_a        = ser_a_q;
    assign bus.ser_b        = ser_b_q;
    assign bus.ser_valid    = ser_valid_q;
    assign bus.ser_first    = ser_first_q;
    assign bus.result       = result_q;
    assign bus.result_valid = result_valid_q;
endmodule
